// File: rtl/uart_rx_if.sv
// ---------------------------------------------------------------------------
// uart_rx_if -- signal bundle between a UART receiver and its environment.
//
// Signals
//   tick         one-clk pulse at BAUD*OVERSAMPLING_RATE (from the baud generator)
//   rx           asynchronous serial line, idle high
//   rx_data      last good word received, LSB = first bit on the line
//   rx_valid     one-clk pulse when rx_data is updated by a good frame
//   frame_error  one-clk pulse when the stop bit samples low
//   busy         high while a frame is being received
//   parity_error one-clk pulse on an even-parity mismatch (UART_RX_PARITY_EN only)
//
// Modports
//   master  environment side: drives tick/rx, observes the receiver outputs
//   slave   receiver side:    observes tick/rx, drives the outputs
//
// Build option: define UART_RX_PARITY_EN to add the parity_error signal.
// ---------------------------------------------------------------------------
interface uart_rx_if #(
  parameter int DATA_BITS = 8
);
  logic                 tick;
  logic                 rx;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 frame_error;
  logic                 busy;
`ifdef UART_RX_PARITY_EN
  logic                 parity_error;

  modport master (
    output tick,
    output rx,
    input  rx_data,
    input  rx_valid,
    input  frame_error,
    input  busy,
    input  parity_error
  );

  modport slave (
    input  tick,
    input  rx,
    output rx_data,
    output rx_valid,
    output frame_error,
    output busy,
    output parity_error
  );
`else
  modport master (
    output tick,
    output rx,
    input  rx_data,
    input  rx_valid,
    input  frame_error,
    input  busy
  );

  modport slave (
    input  tick,
    input  rx,
    output rx_data,
    output rx_valid,
    output frame_error,
    output busy
  );
`endif
endinterface

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx -- oversampling UART receiver.
//
// Receives start + DATA_BITS data bits (LSB first) [+ even parity] + stop.
// The start bit is verified at its mid-point; every later bit is sampled one
// full bit period after the previous sample, i.e. also at its mid-point.
//
// Parameters
//   DATA_BITS          data bits per frame, 5..8
//   OVERSAMPLING_RATE  ticks per bit period, power of two, >= 8
//
// Ports
//   clk   system clock
//   rst   asynchronous active-low reset
//   bus   uart_rx_if.slave: tick, rx in; rx_data, rx_valid, frame_error,
//         busy (and parity_error) out -- all outputs are registered
//
// Build option: define UART_RX_PARITY_EN to add a PARITY state between DATA
// and STOP and the parity_error output.
// ---------------------------------------------------------------------------
module uart_rx #(
  parameter int DATA_BITS         = 8,
  parameter int OVERSAMPLING_RATE = 16
) (
  input  logic     clk,
  input  logic     rst,
  uart_rx_if.slave bus
);

  localparam int CW = $clog2(OVERSAMPLING_RATE);

  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_MID  = CW'(OVERSAMPLING_RATE / 2 - 1);
  localparam logic [CW-1:0] CNT_END  = CW'(OVERSAMPLING_RATE - 1);
  localparam logic [2:0]    LAST_IDX = 3'(DATA_BITS - 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_STOP   = 3'd3;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] ST_PARITY = 3'd4;
`endif

  // synchronizer
  logic                 rx_meta_r;
  logic                 rx_s_r;

  // frame state
  logic [2:0]           state_r;
  logic [2:0]           state_s;
  logic [CW-1:0]        cnt_r;
  logic [CW-1:0]        cnt_s;
  logic [2:0]           idx_r;
  logic [2:0]           idx_s;
  logic [DATA_BITS-1:0] shift_r;
  logic [DATA_BITS-1:0] shift_s;
  logic                 armed_r;
  logic                 armed_s;

  // outputs
  logic [DATA_BITS-1:0] rx_data_r;
  logic [DATA_BITS-1:0] rx_data_s;
  logic                 rx_valid_r;
  logic                 valid_s;
  logic                 frame_error_r;
  logic                 ferr_s;
  logic                 busy_r;

`ifdef UART_RX_PARITY_EN
  logic                 par_bad_r;
  logic                 par_bad_s;
  logic                 parity_error_r;
  logic                 perr_s;
`endif

  logic                 mid_hit_s;
  logic                 end_hit_s;

  // Even parity: the XOR of data bits and parity bit must be zero.
  function automatic logic parity_bad(input logic [DATA_BITS-1:0] data,
                                      input logic                 pbit);
    parity_bad = (^data) ^ pbit;
  endfunction

  // Sample-point strobes: the tick on which the counter sits at a sample value.
  assign mid_hit_s = bus.tick && (cnt_r == CNT_MID);
  assign end_hit_s = bus.tick && (cnt_r == CNT_END);

  // Two-flop synchronizer for the asynchronous serial line (idle high).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_r <= 1'b1;
      rx_s_r    <= 1'b1;
    end else begin
      rx_meta_r <= bus.rx;
      rx_s_r    <= rx_meta_r;
    end
  end

  // Next-state, datapath and output-decision logic.
  always_comb begin
    state_s   = state_r;
    idx_s     = idx_r;
    shift_s   = shift_r;
    armed_s   = 1'b0;            // arming only survives while in IDLE
    rx_data_s = rx_data_r;
    valid_s   = 1'b0;
    ferr_s    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_s = par_bad_r;
    perr_s    = 1'b0;
`endif
    case (state_r)
      ST_IDLE: begin
        // A falling edge only counts once the line has been seen high in IDLE,
        // so a line held low (break, or a failed stop bit) cannot retrigger.
        if (armed_r && !rx_s_r) begin
          state_s = ST_START;
        end else begin
          armed_s = armed_r | rx_s_r;
        end
      end

      ST_START: begin
        if (mid_hit_s) begin
          if (rx_s_r) begin
            state_s = ST_IDLE;     // glitch / false start
          end else begin
            state_s = ST_DATA;
            idx_s   = 3'd0;
          end
        end else begin
          state_s = ST_START;
        end
      end

      ST_DATA: begin
        if (end_hit_s) begin
          shift_s = {rx_s_r, shift_r[DATA_BITS-1:1]};
          if (idx_r == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
            state_s = ST_PARITY;
`else
            state_s = ST_STOP;
`endif
            idx_s   = 3'd0;
          end else begin
            idx_s   = idx_r + 3'd1;
          end
        end else begin
          shift_s = shift_r;
        end
      end

`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (end_hit_s) begin
          par_bad_s = parity_bad(shift_r, rx_s_r);
          state_s   = ST_STOP;
        end else begin
          par_bad_s = par_bad_r;
        end
      end
`endif

      ST_STOP: begin
        // Leaving at the stop-bit mid-point leaves half a bit to re-arm,
        // so a back-to-back start edge is still caught.
        if (end_hit_s) begin
          state_s = ST_IDLE;
          if (rx_s_r) begin
            rx_data_s = shift_r;
            valid_s   = 1'b1;
          end else begin
            ferr_s    = 1'b1;
          end
`ifdef UART_RX_PARITY_EN
          perr_s = par_bad_r;
`endif
        end else begin
          state_s = ST_STOP;
        end
      end

      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Tick counter: advances on tick, restarts on every state change so each
  // state measures its sample point from its own entry.
  always_comb begin
    if (state_s != state_r) begin
      cnt_s = CNT_ZERO;
    end else if (bus.tick) begin
      cnt_s = cnt_r + CNT_ONE;      // wraps naturally across DATA bits
    end else begin
      cnt_s = cnt_r;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r        <= ST_IDLE;
      cnt_r          <= CNT_ZERO;
      idx_r          <= 3'd0;
      shift_r        <= {DATA_BITS{1'b0}};
      armed_r        <= 1'b0;
      rx_data_r      <= {DATA_BITS{1'b0}};
      rx_valid_r     <= 1'b0;
      frame_error_r  <= 1'b0;
      busy_r         <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_r      <= 1'b0;
      parity_error_r <= 1'b0;
`endif
    end else begin
      state_r        <= state_s;
      cnt_r          <= cnt_s;
      idx_r          <= idx_s;
      shift_r        <= shift_s;
      armed_r        <= armed_s;
      rx_data_r      <= rx_data_s;
      rx_valid_r     <= valid_s;
      frame_error_r  <= ferr_s;
      busy_r         <= (state_s != ST_IDLE);   // tracks state_r exactly
`ifdef UART_RX_PARITY_EN
      par_bad_r      <= par_bad_s;
      parity_error_r <= perr_s;
`endif
    end
  end

  assign bus.rx_data      = rx_data_r;
  assign bus.rx_valid     = rx_valid_r;
  assign bus.frame_error  = frame_error_r;
  assign bus.busy         = busy_r;
`ifdef UART_RX_PARITY_EN
  assign bus.parity_error = parity_error_r;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx -- self-checking bench for uart_rx (8 data bits, 16x oversampling,
// tick every 4 clk, so one bit period is 64 clk). Frames are described at the
// bit level; the expected outcome of each frame (good word, frame error,
// parity error) is derived from the frame contents alone.
// ---------------------------------------------------------------------------
module tb_uart_rx;

  localparam int DB       = 8;
  localparam int OSR      = 16;
  localparam int BIT_CLKS = OSR * 4;

  logic clk = 1'b0;
  logic rst = 1'b0;

  uart_rx_if #(.DATA_BITS(DB)) bus ();

  uart_rx #(.DATA_BITS(DB), .OVERSAMPLING_RATE(OSR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  // pulse monitor (high-cycle counts, so a 2-clk pulse counts twice)
  int valid_hi = 0;
  int ferr_hi  = 0;
  int both_hi  = 0;
  int perr_hi  = 0;

  // reference: the word rx_data should hold
  logic [7:0] exp_data = 8'h00;

  always @(negedge clk) begin
    if (bus.rx_valid === 1'b1) valid_hi <= valid_hi + 1;
    if (bus.frame_error === 1'b1) ferr_hi <= ferr_hi + 1;
    if (bus.rx_valid === 1'b1 && bus.frame_error === 1'b1) both_hi <= both_hi + 1;
`ifdef UART_RX_PARITY_EN
    if (bus.parity_error === 1'b1) perr_hi <= perr_hi + 1;
`endif
  end

  // tick: one clk high every 4 clk, driven away from the active edge
  initial begin
    bus.tick = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      bus.tick = 1'b1;
      @(negedge clk);
      bus.tick = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    bus.rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic b);
    bus.rx = b;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  // Send one frame and check its outcome against the frame-level model.
  task automatic send_frame(input string tag, input logic [7:0] data,
                            input logic par_bit, input logic stop_bit);
    int v0;
    int f0;
    int p0;
    logic [31:0] exp_v;
    logic [31:0] exp_f;
    v0 = valid_hi;
    f0 = ferr_hi;
    p0 = perr_hi;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(data[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(par_bit);
`endif
    drive_bit(stop_bit);
    if (stop_bit) exp_data = data;
    exp_v = stop_bit ? 32'd1 : 32'd0;
    exp_f = stop_bit ? 32'd0 : 32'd1;
    check({tag, " rx_valid"},    32'(valid_hi - v0), exp_v);
    check({tag, " frame_error"}, 32'(ferr_hi - f0),  exp_f);
    check({tag, " rx_data"},     32'(bus.rx_data),   32'(exp_data));
    check({tag, " busy"},        32'(bus.busy),      32'd0);
`ifdef UART_RX_PARITY_EN
    check({tag, " parity_error"}, 32'(perr_hi - p0), ((^data) ^ par_bit) ? 32'd1 : 32'd0);
`else
    check({tag, " parity_bit"}, 32'(perr_hi - p0), 32'(par_bit & 1'b0));
`endif
  endtask

  initial begin
    logic [7:0] partial;
    logic [7:0] rnd;
    logic       stop;
    logic       pbit;
    int         v0;
    int         f0;

    bus.rx = 1'b1;
    rst    = 1'b0;
    repeat (5) @(negedge clk);
    check("reset rx_valid",    32'(bus.rx_valid),    32'd0);
    check("reset frame_error", 32'(bus.frame_error), 32'd0);
    check("reset busy",        32'(bus.busy),        32'd0);
    check("reset rx_data",     32'(bus.rx_data),     32'd0);
    rst = 1'b1;
    idle(20);

    // single good frame
    send_frame("a5", 8'hA5, 1'b0, 1'b1);
    idle(20);

    // short low pulse: false start
    v0 = valid_hi;
    f0 = ferr_hi;
    bus.rx = 1'b0;
    repeat (16) @(negedge clk);
    check("false start busy during", 32'(bus.busy), 32'd1);
    bus.rx = 1'b1;
    repeat (8) @(negedge clk);
    check("false start busy before mid", 32'(bus.busy), 32'd1);
    repeat (40) @(negedge clk);
    check("false start busy after", 32'(bus.busy),      32'd0);
    check("false start rx_valid",   32'(valid_hi - v0), 32'd0);
    check("false start frame_err",  32'(ferr_hi - f0),  32'd0);

    // bad stop bit, then line held low
    send_frame("3c badstop", 8'h3C, 1'b0, 1'b0);
    v0 = valid_hi;
    f0 = ferr_hi;
    repeat (300) @(negedge clk);
    check("break busy",        32'(bus.busy),      32'd0);
    check("break rx_valid",    32'(valid_hi - v0), 32'd0);
    check("break frame_error", 32'(ferr_hi - f0),  32'd0);
    idle(20);

    // back-to-back frames, no idle gap
    send_frame("b2b 00", 8'h00, 1'b0, 1'b1);
    send_frame("b2b ff", 8'hFF, 1'b0, 1'b1);
    idle(20);

    // reset in the middle of a frame
    partial = 8'h5A;
    v0 = valid_hi;
    f0 = ferr_hi;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(partial[i]);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("midreset busy",    32'(bus.busy),    32'd0);
    check("midreset rx_data", 32'(bus.rx_data), 32'd0);
    exp_data = 8'h00;
    bus.rx = 1'b1;
    rst = 1'b1;
    repeat (BIT_CLKS * 6) @(negedge clk);
    check("midreset rx_valid",    32'(valid_hi - v0), 32'd0);
    check("midreset frame_error", 32'(ferr_hi - f0),  32'd0);
    check("midreset idle busy",   32'(bus.busy),      32'd0);
    send_frame("81 after reset", 8'h81, 1'b0, 1'b1);
    idle(20);

`ifdef UART_RX_PARITY_EN
    send_frame("07 par0", 8'h07, 1'b0, 1'b1);
    idle(20);
    send_frame("07 par1", 8'h07, 1'b1, 1'b1);
    idle(20);
`endif

    // random frames: random data, occasional bad stop / parity, random gaps
    for (int n = 0; n < 8; n++) begin
      rnd  = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 3) != 0);
      pbit = ($urandom_range(0, 3) == 0) ? ~(^rnd) : (^rnd);
      send_frame($sformatf("rand%0d", n), rnd, pbit, stop);
      idle($urandom_range(8, 80));
    end

    check("valid and frame_error never together", 32'(both_hi), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
